// File: rtl/fifo_async_pkg.sv
// Shared definitions for the asynchronous circular FIFO.
//
// Contents:
//   bin2gray / gray2bin : pointer code conversion. They work on 32-bit values;
//                         callers zero-extend narrower pointers and size-cast
//                         the result back to the pointer width.
//   ADDR_W / DEPTH      : RAM address width and depth for the default 4-bit
//                         pointer. Modules that take PTR_WIDTH as a parameter
//                         derive their own widths from it.
//   OBUF_DEPTH          : number of entries in the read-side output buffer.
package fifo_async_pkg;

  localparam int PTR_WIDTH_DEFAULT = 4;
  localparam int ADDR_W            = PTR_WIDTH_DEFAULT - 1;
  localparam int DEPTH             = 2 ** ADDR_W;
  localparam int OBUF_DEPTH        = 2;

  // Adjacent pointer values differ in exactly one bit once gray coded,
  // which makes the pointer safe to pass through a plain flop synchronizer.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at and above its position.
  // Zero upper bits contribute nothing, so zero-extended inputs convert
  // correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// N-bit two-flop synchronizer.
//
// Ports:
//   clk_i  : destination-domain clock
//   rst_i  : synchronous active-high reset, clears both stages
//   d_i    : N-bit value from the other clock domain (gray coded by the sender)
//   q_o    : value after two destination-clock flops
//
// Both FIFO sides use this block: the read side for the write pointer and the
// write side for the read pointer.
module fifo_sync_2ff #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] stage1_q;

  // The first stage may go metastable; the second stage gives it a full
  // clock period to settle before anything downstream looks at the value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage1_q <= '0;
      q_o      <= '0;
    end else begin
      stage1_q <= d_i;
      q_o      <= stage1_q;
    end
  end

endmodule

// File: rtl/fifo_async_read_ctrl.sv
// Read-domain controller for the asynchronous circular FIFO.
//
// It synchronizes the write side's gray pointer, owns the binary and gray
// read pointers, keeps a registered empty flag, issues reads to the
// dual-port RAM and presents the data through a 2-entry valid/ready buffer.
//
// Ports:
//   clk_in           : read-domain clock
//   rst_in           : synchronous active-high reset
//   wptr_g_in        : gray write pointer from the write domain (asynchronous)
//   rptr_g_out       : registered gray read pointer, goes to the write side
//   rptr_b_out       : registered binary read pointer
//   mem_re_out       : RAM read enable
//   raddr_out        : RAM read address (low bits of rptr_b_out)
//   rdata_in         : RAM read data, valid the cycle after mem_re_out
//   empty_out        : registered flag, RAM holds no unread word
//   data_out         : head word of the output buffer
//   valid_out        : data_out is valid
//   ready_in         : consumer takes data_out when valid_out & ready_in
//   level_out        : (FIFO_RD_LEVEL_EN) registered count of unread RAM words
//   almost_empty_out : (FIFO_RD_LEVEL_EN) registered level <= AE_THRESH
//
// Build option: define FIFO_RD_LEVEL_EN to add level_out, almost_empty_out
// and the AE_THRESH parameter.
module fifo_async_read_ctrl
  import fifo_async_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
`ifdef FIFO_RD_LEVEL_EN
  ,
  parameter int AE_THRESH = 1
`endif
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [PTR_WIDTH-1:0] wptr_g_in,
  output logic [PTR_WIDTH-1:0] rptr_g_out,
  output logic [PTR_WIDTH-1:0] rptr_b_out,
  output logic                 mem_re_out,
  output logic [PTR_WIDTH-2:0] raddr_out,
  input  logic [WIDTH-1:0]     rdata_in,
  output logic                 empty_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  input  logic                 ready_in
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [PTR_WIDTH-1:0] level_out,
  output logic                 almost_empty_out
`endif
);

  localparam int ObufIdxW = $clog2(OBUF_DEPTH);
  localparam int HeldW    = $clog2(OBUF_DEPTH + 1);

  logic [PTR_WIDTH-1:0] wptrGraySync;
  logic [PTR_WIDTH-1:0] wptrBinSync;

  logic [PTR_WIDTH-1:0] rptrBin_q, rptrBin_d;
  logic [PTR_WIDTH-1:0] rptrGray_q, rptrGray_d;
  logic                 empty_q, empty_d;
  logic                 inflight_q;

  logic [WIDTH-1:0]     obuf_q [OBUF_DEPTH];
  logic [ObufIdxW-1:0]  head_q, tail_q;
  logic [HeldW-1:0]     held_q;

  logic                 pop;
  logic                 issue;
  logic [2:0]           occ;
  logic [2:0]           occAfterPop;

  fifo_sync_2ff #(
    .N (PTR_WIDTH)
  ) uWptrSync (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (wptr_g_in),
    .q_o   (wptrGraySync)
  );

  assign wptrBinSync = PTR_WIDTH'(gray2bin(32'(wptrGraySync)));

  // Occupancy counts the words already held plus the one that may be on its
  // way back from the RAM. A new read goes out only if, after this cycle's
  // pop, that read still has a buffer slot waiting for it.
  always_comb begin
    pop         = valid_out & ready_in;
    occ         = 3'(held_q) + 3'(inflight_q);
    occAfterPop = occ - 3'(pop);
    issue       = ~empty_q & (occAfterPop < 3'd2);
    rptrBin_d   = issue ? rptrBin_q + 1'b1 : rptrBin_q;
    rptrGray_d  = PTR_WIDTH'(bin2gray(32'(rptrBin_d)));
    // The flag compares the pointer as it will be after this edge; using the
    // current one would let a second read slip out after the last word.
    empty_d     = (rptrGray_d == wptrGraySync);
  end

  // Read pointers, empty flag and the one-cycle RAM latency tracker.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rptrBin_q  <= '0;
      rptrGray_q <= '0;
      empty_q    <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rptrBin_q  <= rptrBin_d;
      rptrGray_q <= rptrGray_d;
      empty_q    <= empty_d;
      inflight_q <= issue;
    end
  end

  // Output buffer: a 2-entry ring. The word requested last cycle is written
  // at the tail while the consumer may take the head in the same cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      held_q <= '0;
    end else begin
      if (inflight_q) begin
        obuf_q[tail_q] <= rdata_in;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      held_q <= held_q + HeldW'(inflight_q) - HeldW'(pop);
    end
  end

  assign rptr_b_out = rptrBin_q;
  assign rptr_g_out = rptrGray_q;
  assign raddr_out  = rptrBin_q[PTR_WIDTH-2:0];
  assign mem_re_out = issue;
  assign empty_out  = empty_q;
  assign valid_out  = (held_q != '0);
  assign data_out   = obuf_q[head_q];

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_WIDTH-1:0] level_d;

  // Level is taken against the post-edge read pointer so it agrees with
  // rptr_b_out in the same cycle.
  always_comb begin
    level_d = wptrBinSync - rptrBin_d;
  end

  // Registered fill level and almost-empty flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      level_out        <= '0;
      almost_empty_out <= 1'b1;
    end else begin
      level_out        <= level_d;
      almost_empty_out <= (32'(level_d) <= $unsigned(AE_THRESH));
    end
  end
`else
  logic unusedWptrBin;
  assign unusedWptrBin = ^wptrBinSync;
`endif

`ifndef SYNTHESIS
  // The issue rule keeps held words plus the pending read at two or fewer.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      assert (occ <= 3'd2);
    end
  end
`endif

endmodule

// File: doc/fifo_async_read_ctrl.md
Name: fifo_async_read_ctrl

Overview:
Read-domain controller for the asynchronous circular FIFO, directly downstream of the write-pointer stage. It brings the write-side gray pointer across with a 2-flop synchronizer and owns the binary and gray read pointers. It derives a registered empty flag, issues reads to the dual-port RAM, and presents data through a 2-entry valid/ready output buffer. Its gray read pointer feeds the write-side synchronizer.

Parameters:
WIDTH, 8, data word width.
PTR_WIDTH, 4, pointer width incl. wrap bit; RAM depth = 2**(PTR_WIDTH-1); address = PTR_WIDTH-1 bits.
AE_THRESH, 1, almost-empty threshold (used only with FIFO_RD_LEVEL_EN).

Ports:
clk_in  in  1  read-domain clock; all flops on rising edge.
rst_in  in  1  synchronous, active-high reset.
wptr_g_in  in  PTR_WIDTH  gray write pointer from write domain (asynchronous).
rptr_g_out  out  PTR_WIDTH  registered gray read pointer to write-side sync.
rptr_b_out  out  PTR_WIDTH  registered binary read pointer.
mem_re_out  out  1  RAM read enable.
raddr_out  out  PTR_WIDTH-1  RAM read address = rptr_b_out[PTR_WIDTH-2:0].
rdata_in  in  WIDTH  RAM read data, valid the cycle after mem_re_out.
empty_out  out  1  registered: RAM holds no unread word.
data_out  out  WIDTH  head word of output buffer.
valid_out  out  1  data_out valid.
ready_in  in  1  consumer accepts data_out when valid_out & ready_in.

Behaviour:
- Reset: one clock, synchronous, active-high (rst_in), as decided. Sync flops, rptr_b_out, rptr_g_out, buffer pointers, inflight all 0. empty_out=1, valid_out=0, mem_re_out=0, data_out=0.
- Reset mid-operation: buffered and inflight data discarded. Pointers return to 0. The write side must be reset in the same window.
- Sync: wptr_g_in -> s1 -> s2 (2 flops); gray-to-binary on s2 gives wptr_b_sync.
- pop = valid_out & ready_in. occ = held entries (0..2) + inflight (0/1).
- issue (= mem_re_out, combinational) = ~empty_out & ((occ - pop) < 2).
- On issue: rptr_b_next = rptr_b_out + 1 (mod 2**PTR_WIDTH), else hold. rptr_g_next = (rptr_b_next>>1) ^ rptr_b_next. Both registered.
- empty_out <= (rptr_g_next == s2). Evaluating against the next pointer prevents a double read after the last word.
- inflight <= issue. When inflight, rdata_in is written into the buffer tail at that edge.
- Output buffer: 2-entry circular. valid_out = held != 0. data_out = head entry. Simultaneous push and pop are allowed: count unchanged, head/tail both advance.
- Throughput: 1 word/cycle sustained while RAM is non-empty and ready_in=1.
- Latency: write-pointer update -> empty_out deasserts after 3 read clocks (2 sync + 1 flag). empty_out low -> valid_out high 2 cycles later (issue, capture).
- Wrap-around: pointers wrap modulo 2**PTR_WIDTH; the MSB toggles per RAM lap. Empty compares full gray words.
- ready_in with valid_out=0 is ignored. data_out is stable while valid_out & ~ready_in.
- Overflow is impossible by construction. The occ <= 2 invariant is asserted in simulation.

Optional Feature:
FIFO_RD_LEVEL_EN:
- Defined: adds ports level_out (PTR_WIDTH, registered) = wptr_b_sync - rptr_b_out mod 2**PTR_WIDTH, and almost_empty_out (1, registered) = level_next <= AE_THRESH. Reset values: level_out=0, almost_empty_out=1.
- Undefined: both ports and their logic are absent; AE_THRESH is unused.

Decomposition:
- Shared package fifo_async_pkg holds:
  - bin2gray/gray2bin functions.
  - localparams ADDR_W = PTR_WIDTH-1 and DEPTH = 2**ADDR_W.
  - the output-buffer depth constant OBUF_DEPTH = 2.
- One sub-module: fifo_sync_2ff (parameterised N-bit 2-flop synchronizer, synchronous active-high reset). It is reused by the write side for rptr_g_out.

Test Plan:
- Reset: rst_in=1 for 2 cycles with wptr_g_in=4'b0110 -> empty_out=1, valid_out=0, rptr_g_out=0, mem_re_out=0. After release, empty_out falls 3 cycles later.
- Single word: wptr_g_in 0->1 with RAM[0]=0xA5, ready_in=1 -> mem_re_out raddr=0 once; data_out=0xA5, valid_out 1 cycle; then rptr_b_out=1, empty_out=1, no second read.
- Back-pressure: 5 words 0x10..0x14, ready_in=0 -> exactly 2 reads issued, valid_out=1 holding 0x10. Raise ready_in -> 0x10..0x14 delivered on consecutive cycles, in order.
- Wrap-around: 20 words streamed, PTR_WIDTH=4 -> rptr_b_out passes 15->0, rptr_g_out 4'b1000->4'b0000. Data in order, no loss or duplication.
- Mid-run reset: rst_in asserted with 2 held + 1 inflight -> next cycle valid_out=0, pointers 0; inflight rdata_in is not captured.
- With FIFO_RD_LEVEL_EN, AE_THRESH=1: wptr=6, rptr=0 -> level_out=6, almost_empty_out=0. After 5 reads -> level_out=1, almost_empty_out=1.
